main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller_pkg.sv | 53 +++++
 rtl/main_controller_alu_decoder.sv | 23 ++
 rtl/main_controller.sv | 137 +++++++++++++
 tb/tb_main_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/main_controller_pkg.sv
// Shared encodings for the multicycle main controller: state codes, opcode/funct
// fields, ALU operation selects and ALU operand-B selects.
package main_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_LBADDR  = 4'd2,
    S_LBRD    = 4'd3,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ADDIEX  = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ILLEGAL = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  // DECODE dispatch: anything not recognised lands in the absorbing ILLEGAL state.
  function automatic state_e decode_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE: decode_opcode = S_RTYPEEX;
      OP_LB:    decode_opcode = S_LBADDR;
      OP_SB:    decode_opcode = S_SBWR;
      OP_ADDI:  decode_opcode = S_ADDIEX;
      OP_BEQ:   decode_opcode = S_BEQEX;
      OP_J:     decode_opcode = S_JEX;
      default:  decode_opcode = S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/main_controller_alu_decoder.sv
// R-type funct to ALU operation decode, with a flag for supported funct codes.
module alu_decoder
  import main_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       legal
);

  always_comb begin
    alucont = ALU_ADD;
    legal   = 1'b1;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_SUB:  alucont = ALU_SUB;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Multicycle main controller FSM: fetch/decode/execute sequencing, memory
// handshake, PC update pulses, per-instruction retire and sticky illegal flag.
module main_controller
  import main_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic [3:0] state,
  output logic [2:0] alucont,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       mem_req,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_branch,
  output logic       pc_jump,
  output logic       retire,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] rtype_alucont;
  logic       funct_legal;

  alu_decoder u_alu_dec (
    .funct   (funct),
    .alucont (rtype_alucont),
    .legal   (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alucont   = ALU_ADD;
    alusrca   = 1'b0;
    alusrcb   = SRCB_REG;
    mem_req   = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    pc_jump   = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = decode_opcode(opcode);
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alucont = rtype_alucont;
        if (funct_legal) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      // Loads and stores share address generation and hold it across the wait.
      S_LBADDR, S_SBWR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) begin
          if (state_q == S_SBWR) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_LBRD;
          end
        end
      end
      S_LBRD: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQEX: begin
        alusrca   = 1'b1;
        alucont   = ALU_SUB;
        pc_branch = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JEX: begin
        pc_jump = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase

    // Reset forces FETCH asynchronously; keep the request and pulses quiet
    // until it releases so an interrupted access is abandoned cleanly.
    if (!rst_n) begin
      mem_req   = 1'b0;
      ir_write  = 1'b0;
      pc_inc    = 1'b0;
      pc_branch = 1'b0;
      pc_jump   = 1'b0;
      retire    = 1'b0;
    end
  end

  assign illegal_d = illegal_q | (state_d == S_ILLEGAL);
  assign state     = state_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed-vector bench: stimulus pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_main_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ack;
  logic [3:0] state;
  logic [2:0] alucont;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       mem_req, iord, ir_write, pc_inc, pc_branch, pc_jump, retire, illegal;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] ac;
    logic       sa;
    logic [1:0] sb;
    logic       mr, io, irw, pci, pcb, pcj, ret, ill;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  main_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .state(state), .alucont(alucont), .alusrca(alusrca),
    .alusrcb(alusrcb), .mem_req(mem_req), .iord(iord), .ir_write(ir_write),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump), .retire(retire),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Per-state expected output rows (fields: st ac sa sb mr io irw pci pcb pcj ret ill).
  function automatic obs_t ev(input logic [3:0] st, input logic [2:0] ac, input logic sa,
                              input logic [1:0] sb, input logic mr, input logic io,
                              input logic irw, input logic pci, input logic pcb,
                              input logic pcj, input logic ret, input logic ill);
    ev = '{st, ac, sa, sb, mr, io, irw, pci, pcb, pcj, ret, ill};
  endfunction
  function automatic obs_t e_rst();              return ev(4'd0, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic obs_t e_fetch(input logic a); return ev(4'd0, 3'b010, 0, 2'b00, 1, 0, a, a, 0, 0, 0, 0); endfunction
  function automatic obs_t e_dec();              return ev(4'd1, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic obs_t e_rtype(input logic [2:0] ac, input logic r);
    return ev(4'd6, ac, 1, 2'b00, 0, 0, 0, 0, 0, 0, r, 0);
  endfunction
  function automatic obs_t e_lbaddr();           return ev(4'd2, 3'b010, 1, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic obs_t e_lbrd();             return ev(4'd3, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic obs_t e_sbwr(input logic r); return ev(4'd5, 3'b010, 1, 2'b10, 1, 1, 0, 0, 0, 0, r, 0); endfunction
  function automatic obs_t e_addi();             return ev(4'd7, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic obs_t e_beq(input logic z); return ev(4'd8, 3'b110, 1, 2'b00, 0, 0, 0, 0, z, 0, 1, 0); endfunction
  function automatic obs_t e_j();                return ev(4'd9, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0); endfunction
  function automatic obs_t e_ill();              return ev(4'd15, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1); endfunction

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic ack, input obs_t e, input string nm);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; mem_ack = ack; rst_n = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Fetch with immediate ack, then decode with a stray ack that must be ignored.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    step(1, op, fn, 0, 1, e_fetch(1), "fetch");
    step(1, op, fn, 0, 1, e_dec(), "decode_stray_ack");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{state, alucont, alusrca, alusrcb, mem_req, iord, ir_write, pc_inc,
             pc_branch, pc_jump, retire, illegal};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d ac=%b sa=%b sb=%b mr=%b io=%b irw=%b pci=%b pcb=%b pcj=%b ret=%b ill=%b, want st=%0d ac=%b sa=%b sb=%b mr=%b io=%b irw=%b pci=%b pcb=%b pcj=%b ret=%b ill=%b",
                 nm, a.st, a.ac, a.sa, a.sb, a.mr, a.io, a.irw, a.pci, a.pcb, a.pcj, a.ret, a.ill,
                 e.st, e.ac, e.sa, e.sb, e.mr, e.io, e.irw, e.pci, e.pcb, e.pcj, e.ret, e.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    logic [5:0] fns [5];
    logic [2:0] acs [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    acs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;

    step(0, 6'b0, 6'b0, 0, 1, e_rst(), "reset_state");
    step(1, 6'b0, 6'b0, 0, 0, e_fetch(0), "post_reset_fetch_wait");

    // R-type funct table; first entry is the ADD scenario.
    for (int i = 0; i < 5; i++) begin
      fetch_decode(6'b000000, fns[i]);
      step(1, 6'b000000, fns[i], 0, 0, e_rtype(acs[i], 1), "rtype_exec");
    end

    // LB: instruction fetch waits one cycle, data ack delayed 3 cycles.
    step(1, 6'b100000, 6'b0, 0, 0, e_fetch(0), "lb_fetch_wait");
    fetch_decode(6'b100000, 6'b0);
    for (int i = 0; i < 3; i++) step(1, 6'b100000, 6'b0, 0, 0, e_lbaddr(), "lbaddr_wait");
    step(1, 6'b100000, 6'b0, 0, 1, e_lbaddr(), "lbaddr_ack");
    step(1, 6'b100000, 6'b0, 0, 0, e_lbrd(), "lbrd_retire");

    // SB with one wait cycle.
    fetch_decode(6'b101000, 6'b0);
    step(1, 6'b101000, 6'b0, 0, 0, e_sbwr(0), "sbwr_wait");
    step(1, 6'b101000, 6'b0, 0, 1, e_sbwr(1), "sbwr_ack_retire");

    fetch_decode(6'b001000, 6'b0);
    step(1, 6'b001000, 6'b0, 0, 0, e_addi(), "addi_exec");

    fetch_decode(6'b000100, 6'b0);
    step(1, 6'b000100, 6'b0, 1, 0, e_beq(1), "beq_taken");
    fetch_decode(6'b000100, 6'b0);
    step(1, 6'b000100, 6'b0, 0, 0, e_beq(0), "beq_not_taken");

    fetch_decode(6'b000010, 6'b0);
    step(1, 6'b000010, 6'b0, 0, 0, e_j(), "jump_exec");

    // Unsupported funct: no retire, then absorbed into ILLEGAL.
    fetch_decode(6'b000000, 6'b000000);
    step(1, 6'b000000, 6'b000000, 0, 1, e_rtype(3'b010, 0), "rtype_bad_funct");
    for (int i = 0; i < 3; i++) step(1, 6'b000000, 6'b0, 0, 1, e_ill(), "illegal_hold_funct");
    step(0, 6'b000000, 6'b0, 0, 0, e_rst(), "reset_clears_illegal");
    step(1, 6'b111111, 6'b0, 0, 0, e_fetch(0), "release_fetch");

    // Unknown opcode: ILLEGAL for 20 cycles with mem_ack toggling.
    fetch_decode(6'b111111, 6'b0);
    for (int i = 0; i < 20; i++) step(1, 6'b111111, 6'b0, 0, 1'(i & 1), e_ill(), "illegal_absorb");
    step(0, 6'b111111, 6'b0, 0, 1, e_rst(), "reset_from_illegal");
    step(1, 6'b101000, 6'b0, 0, 0, e_fetch(0), "release_fetch2");

    // Reset dropped mid-store request, checked before the next clock edge.
    fetch_decode(6'b101000, 6'b0);
    step(1, 6'b101000, 6'b0, 0, 0, e_sbwr(0), "sbwr_before_reset");
    step(0, 6'b101000, 6'b0, 0, 1, e_rst(), "reset_mid_sbwr");
    step(1, 6'b101000, 6'b0, 0, 0, e_fetch(0), "fetch_after_release");
    step(1, 6'b101000, 6'b0, 0, 1, e_fetch(1), "fetch_ack_after_release");
    step(1, 6'b101000, 6'b0, 0, 0, e_dec(), "decode_after_release");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
